// File: rtl/riscv_mem_arbiter.sv
// Single-port SRAM arbiter shared by the instruction fetch and data ports.
// Data wins by default; a bounded starvation counter guarantees fetch progress.
module riscv_mem_arbiter #(
   parameter int MEM_AW     = 14,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [0:0] ST_ACCEPT = 1'b0;
   localparam logic [0:0] ST_RMW_WR = 1'b1;
   localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

   logic [0:0]        state_q, state_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              i_rvalid_q, i_rvalid_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [MEM_AW-1:0] rmw_addr_q, rmw_addr_d;
   logic [31:0]       rmw_wdata_q, rmw_wdata_d;
   logic [3:0]        rmw_be_q, rmw_be_d;

   logic              i_gnt_s, d_gnt_s, mem_en_s, mem_we_s;
   logic [MEM_AW-1:0] mem_addr_s;
   logic [31:0]       mem_wdata_s;
   logic              unused_s;

   function automatic logic [31:0] merge_lanes(input logic [31:0] new_w,
                                               input logic [31:0] old_w,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = 32'h0000_0000;
      for (int l = 0; l < 4; l++) begin
         res[8*l +: 8] = be[l] ? new_w[8*l +: 8] : old_w[8*l +: 8];
      end
      return res;
   endfunction

   // Arbitration, SRAM strobes and next-state; everything is held quiet while rstn is low.
   always_comb begin
      i_gnt_s      = 1'b0;
      d_gnt_s      = 1'b0;
      mem_en_s     = 1'b0;
      mem_we_s     = 1'b0;
      mem_addr_s   = '0;
      mem_wdata_s  = 32'h0000_0000;
      i_rvalid_d   = 1'b0;
      d_rvalid_d   = 1'b0;
      state_d      = state_q;
      rmw_addr_d   = rmw_addr_q;
      rmw_wdata_d  = rmw_wdata_q;
      rmw_be_d     = rmw_be_q;
      if (!rstn) begin
         state_d = ST_ACCEPT;
      end else begin
         case (state_q)
            ST_ACCEPT: begin
               if (d_req && !(i_req && (starve_cnt_q == STARVE_LIM))) begin
                  d_gnt_s = 1'b1;
                  if (!d_we) begin
                     mem_en_s   = 1'b1;
                     mem_addr_s = d_addr[MEM_AW+1:2];
                     d_rvalid_d = 1'b1;
                  end else if (d_be == 4'hF) begin
                     mem_en_s    = 1'b1;
                     mem_we_s    = 1'b1;
                     mem_addr_s  = d_addr[MEM_AW+1:2];
                     mem_wdata_s = d_wdata;
                  end else if (d_be != 4'h0) begin
                     // Partial store: fetch the old word now, merge and write next cycle.
                     mem_en_s    = 1'b1;
                     mem_addr_s  = d_addr[MEM_AW+1:2];
                     rmw_addr_d  = d_addr[MEM_AW+1:2];
                     rmw_wdata_d = d_wdata;
                     rmw_be_d    = d_be;
                     state_d     = ST_RMW_WR;
                  end else begin
                     mem_en_s = 1'b0;
                  end
               end else if (i_req) begin
                  i_gnt_s    = 1'b1;
                  mem_en_s   = 1'b1;
                  mem_addr_s = i_addr[MEM_AW+1:2];
                  i_rvalid_d = 1'b1;
               end else begin
                  state_d = ST_ACCEPT;
               end
            end
            ST_RMW_WR: begin
               mem_en_s    = 1'b1;
               mem_we_s    = 1'b1;
               mem_addr_s  = rmw_addr_q;
               mem_wdata_s = merge_lanes(rmw_wdata_q, mem_rdata, rmw_be_q);
               state_d     = ST_ACCEPT;
            end
            default: begin
               state_d = ST_ACCEPT;
            end
         endcase
      end
   end

   // Starvation counter: counts data grants that overtook a pending fetch.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!i_req || i_gnt_s) begin
         starve_cnt_d = 4'h0;
      end else if (d_gnt_s && (starve_cnt_q < STARVE_LIM)) begin
         starve_cnt_d = starve_cnt_q + 4'h1;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // State, counter, read-valid and RMW latch registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_ACCEPT;
         starve_cnt_q <= 4'h0;
         i_rvalid_q   <= 1'b0;
         d_rvalid_q   <= 1'b0;
         rmw_addr_q   <= '0;
         rmw_wdata_q  <= 32'h0000_0000;
         rmw_be_q     <= 4'h0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         i_rvalid_q   <= i_rvalid_d;
         d_rvalid_q   <= d_rvalid_d;
         rmw_addr_q   <= rmw_addr_d;
         rmw_wdata_q  <= rmw_wdata_d;
         rmw_be_q     <= rmw_be_d;
      end
   end

   assign i_gnt     = i_gnt_s;
   assign d_gnt     = d_gnt_s;
   assign mem_en    = mem_en_s;
   assign mem_we    = mem_we_s;
   assign mem_addr  = mem_addr_s;
   assign mem_wdata = mem_wdata_s;
   assign i_rvalid  = i_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign i_rdata   = i_rvalid_q ? mem_rdata : 32'h0000_0000;
   assign d_rdata   = d_rvalid_q ? mem_rdata : 32'h0000_0000;

   // Byte offset and bits above the SRAM window alias away.
   assign unused_s = ^{i_addr[31:MEM_AW+2], i_addr[1:0], d_addr[31:MEM_AW+2], d_addr[1:0]};

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a behavioural one-cycle-latency SRAM.
module tb_riscv_mem_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
   logic [31:0] i_rdata, d_rdata, mem_wdata;
   logic [31:0] mem_rdata = 32'h0000_0000;
   logic [13:0] mem_addr;
   logic [31:0] mem [0:16383];
   int          errors = 0;
   int          checks = 0;
   int          wr_count = 0;

   always #5 clk = ~clk;

   riscv_mem_arbiter #(.MEM_AW(14), .STARVE_MAX(3)) dut (
      .clk(clk), .rstn(rstn),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // SRAM model: read data one cycle after a read strobe
   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
      if (mem_en && mem_we) begin
         mem[mem_addr] = mem_wdata;
         wr_count = wr_count + 1;
      end
   end

   task automatic idle();
      @(negedge clk);
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
      i_addr = 32'h0000_0010; d_addr = 32'h0000_0020; d_wdata = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      #2;
      checks++;
      if ({i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid} !== 6'b000000) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 000000", {i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid});
      end
      checks++;
      if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 110'h0) begin
         errors++; $display("FAIL reset_data: addr %h wdata %h ird %h drd %h expected all 0", mem_addr, mem_wdata, i_rdata, d_rdata);
      end
      @(negedge clk);
      rstn = 1'b1; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
      #2;
      checks++;
      if (i_gnt !== 1'b1) begin
         errors++; $display("FAIL reset_first_grant: i_gnt %b expected 1", i_gnt);
      end
      idle();
      idle();
   endtask

   task automatic test_fetch();
      mem[4] = 32'hCAFE_0004;
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h0001_0010;
      #2;
      checks++;
      if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 14'd4) begin
         errors++; $display("FAIL fetch_grant: gnt/en/we %b addr %0d expected 1010 addr 4", {i_gnt, d_gnt, mem_en, mem_we}, mem_addr);
      end
      idle();
      #2;
      checks++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'hCAFE_0004 || d_rvalid !== 1'b0) begin
         errors++; $display("FAIL fetch_rvalid: rv %b rdata %h drv %b expected 1 cafe0004 0", i_rvalid, i_rdata, d_rvalid);
      end
      @(negedge clk);
      #2;
      checks++;
      if (i_rvalid !== 1'b0 || i_rdata !== 32'h0000_0000) begin
         errors++; $display("FAIL fetch_rvalid_drop: rv %b rdata %h expected 0 0", i_rvalid, i_rdata);
      end
   endtask

   task automatic test_starve();
      logic [7:0] d_pat;
      d_pat = 8'b0111_0111;
      mem[16] = 32'hA0A0_A0A0;
      mem[32] = 32'hD0D0_D0D0;
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h0000_0040;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
      for (int k = 0; k < 8; k++) begin
         #2;
         checks++;
         if (d_gnt !== d_pat[k] || i_gnt !== ~d_pat[k]) begin
            errors++; $display("FAIL starve_pattern[%0d]: i_gnt %b d_gnt %b expected d_gnt %b", k, i_gnt, d_gnt, d_pat[k]);
         end
         if (k == 4) begin
            checks++;
            if (i_rvalid !== 1'b1 || i_rdata !== 32'hA0A0_A0A0 || d_rvalid !== 1'b0) begin
               errors++; $display("FAIL order_fetch_first: irv %b ird %h drv %b expected 1 a0a0a0a0 0", i_rvalid, i_rdata, d_rvalid);
            end
         end
         if (k == 5) begin
            checks++;
            if (d_rvalid !== 1'b1 || d_rdata !== 32'hD0D0_D0D0 || i_rvalid !== 1'b0) begin
               errors++; $display("FAIL order_load_second: drv %b drd %h irv %b expected 1 d0d0d0d0 0", d_rvalid, d_rdata, i_rvalid);
            end
         end
         @(negedge clk);
      end
      i_req = 1'b0; d_req = 1'b0;
      idle();
   endtask

   task automatic test_rmw();
      mem[8] = 32'h1122_3344;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 32'h0000_0020; d_wdata = 32'h0000_AA00;
      i_req = 1'b1; i_addr = 32'h0000_0040;
      #2;
      checks++;
      if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b0110 || mem_addr !== 14'd8) begin
         errors++; $display("FAIL rmw_read: gnt/en/we %b addr %0d expected 0110 addr 8", {i_gnt, d_gnt, mem_en, mem_we}, mem_addr);
      end
      @(negedge clk);
      d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
      #2;
      checks++;
      if ({i_gnt, d_gnt, mem_en, mem_we, d_rvalid} !== 5'b00110 || mem_addr !== 14'd8 || mem_wdata !== 32'h1122_AA44) begin
         errors++; $display("FAIL rmw_write: gnt/en/we/rv %b addr %0d wdata %h expected 00110 8 1122aa44", {i_gnt, d_gnt, mem_en, mem_we, d_rvalid}, mem_addr, mem_wdata);
      end
      @(negedge clk);
      #2;
      checks++;
      if (i_gnt !== 1'b1 || mem[8] !== 32'h1122_AA44) begin
         errors++; $display("FAIL rmw_after: i_gnt %b word %h expected 1 1122aa44", i_gnt, mem[8]);
      end
      idle();
      idle();
   endtask

   task automatic test_reset_rmw();
      int wr_before;
      mem[9] = 32'h5566_7788;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0001; d_addr = 32'h0000_0024; d_wdata = 32'h0000_00FF;
      #2;
      checks++;
      if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin
         errors++; $display("FAIL rst_rmw_read: d_gnt %b mem_we %b expected 1 0", d_gnt, mem_we);
      end
      @(negedge clk);
      wr_before = wr_count;
      d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; rstn = 1'b0;
      #2;
      checks++;
      if ({mem_en, mem_we, d_gnt, i_gnt, d_rvalid} !== 5'b00000 || mem_wdata !== 32'h0) begin
         errors++; $display("FAIL rst_rmw_quiet: en/we/gnt/rv %b wdata %h expected 00000 0", {mem_en, mem_we, d_gnt, i_gnt, d_rvalid}, mem_wdata);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (wr_count !== wr_before || mem[9] !== 32'h5566_7788) begin
         errors++; $display("FAIL rst_rmw_word: writes %0d word %h expected %0d 55667788", wr_count, mem[9], wr_before);
      end
      // Pending load data is dropped by reset
      d_req = 1'b1; d_addr = 32'h0000_0024;
      @(negedge clk);
      d_req = 1'b0; rstn = 1'b0;
      #2;
      checks++;
      if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
         errors++; $display("FAIL rst_rvalid_drop: drv %b drd %h expected 0 0", d_rvalid, d_rdata);
      end
      @(negedge clk);
      rstn = 1'b1;
      idle();
   endtask

   task automatic test_store_load();
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h0000_0008; d_wdata = 32'hDEAD_BEEF;
      #2;
      checks++;
      if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 14'd2 || mem_wdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL store_full: gnt/en/we %b addr %0d wdata %h expected 111 2 deadbeef", {d_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
      end
      @(negedge clk);
      d_we = 1'b0; d_be = 4'h0;
      #2;
      checks++;
      if (d_gnt !== 1'b1 || mem_we !== 1'b0 || d_rvalid !== 1'b0) begin
         errors++; $display("FAIL load_grant: d_gnt %b mem_we %b drv %b expected 1 0 0", d_gnt, mem_we, d_rvalid);
      end
      @(negedge clk);
      d_req = 1'b0;
      #2;
      checks++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL load_data: drv %b drd %h expected 1 deadbeef", d_rvalid, d_rdata);
      end
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 32'h0000_0008; d_wdata = 32'h1234_5678;
      #2;
      checks++;
      if (d_gnt !== 1'b1 || mem_en !== 1'b0 || d_rvalid !== 1'b0) begin
         errors++; $display("FAIL store_noop: d_gnt %b mem_en %b drv %b expected 1 0 0", d_gnt, mem_en, d_rvalid);
      end
      idle();
      #2;
      checks++;
      if (d_rvalid !== 1'b0 || mem[2] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL store_noop_after: drv %b word %h expected 0 deadbeef", d_rvalid, mem[2]);
      end
   endtask

   initial begin
      for (int a = 0; a < 16384; a++) mem[a] = 32'h0000_0000;
      test_reset();
      test_fetch();
      test_starve();
      test_rmw();
      test_reset_rmw();
      test_store_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_AW, default 14, meaning SRAM word-address width.
REQ-002 SHALL have parameter STARVE_MAX, default 3, meaning the maximum consecutive data grants allowed while i_req is pending (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_req, input, 1 bit: instruction fetch request.
REQ-006 SHALL have port i_addr, input, 32 bits: fetch byte address.
REQ-007 SHALL have port i_gnt, output, 1 bit: fetch accepted this cycle.
REQ-008 SHALL have port i_rvalid, output, 1 bit: fetch data valid.
REQ-009 SHALL have port i_rdata, output, 32 bits: fetch data.
REQ-010 SHALL have port d_req, input, 1 bit: data request.
REQ-011 SHALL have port d_we, input, 1 bit: store (1) or load (0).
REQ-012 SHALL have port d_be, input, 4 bits: store byte enables, bit n = byte lane n.
REQ-013 SHALL have port d_addr, input, 32 bits: data byte address.
REQ-014 SHALL have port d_wdata, input, 32 bits: store data, lane-aligned.
REQ-015 SHALL have port d_gnt, output, 1 bit: data request accepted this cycle.
REQ-016 SHALL have port d_rvalid, output, 1 bit: load data valid.
REQ-017 SHALL have port d_rdata, output, 32 bits: load data (full word).
REQ-018 SHALL have port mem_en, output, 1 bit: SRAM access strobe.
REQ-019 SHALL have port mem_we, output, 1 bit: SRAM write strobe.
REQ-020 SHALL have port mem_addr, output, MEM_AW bits: SRAM word address.
REQ-021 SHALL have port mem_wdata, output, 32 bits: SRAM write data.
REQ-022 SHALL have port mem_rdata, input, 32 bits: SRAM read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-023 SHALL perform at most one SRAM access per cycle; mem_addr = addr[MEM_AW+1:2] of the granted port, upper address bits ignored (aliasing).
REQ-024 SHALL use two states: ACCEPT and RMW_WR; grants are issued only in ACCEPT, with i_gnt/d_gnt combinational from the requests and state.
REQ-025 SHALL grant d_req over i_req in ACCEPT, except that when starve_cnt == STARVE_MAX and i_req=1, i_req SHALL win.
REQ-026 SHALL increment starve_cnt on each d_gnt while i_req=1, and clear it on i_gnt or when i_req=0; starve_cnt SHALL saturate at STARVE_MAX.
REQ-027 SHALL never assert i_gnt and d_gnt in the same cycle.
REQ-028 SHALL, for a granted read (fetch or load) at cycle T: drive mem_en=1, mem_we=0 at T; assert the matching rvalid for exactly one cycle at T+1, with rdata = mem_rdata.
REQ-029 SHALL, for a store with d_be=4'hF: drive mem_en=1, mem_we=1, mem_wdata=d_wdata at T; no d_rvalid; remain in ACCEPT.
REQ-030 SHALL, for a store with partial d_be (neither 0 nor F): issue a read at T, latch address/wdata/be, enter RMW_WR.
REQ-031 SHALL, in RMW_WR at T+1: write mem_wdata = per-lane d_be ? latched wdata : mem_rdata; no grants; no d_rvalid; return to ACCEPT.
REQ-032 SHALL, for a store with d_be=0: grant without any SRAM access (no-op).
REQ-033 SHALL drive i_rdata/d_rdata at 0 when the corresponding rvalid=0.
REQ-034 SHALL, for a load granted at T while a fetch was granted at T-1: deliver i_rvalid at T and d_rvalid at T+1, each for exactly one cycle, in order.

Reset
REQ-035 SHALL, while rstn=0, force state=ACCEPT, starve_cnt=0, and all outputs to 0 (gnts, rvalids, rdata, mem_en, mem_we, mem_addr, mem_wdata).
REQ-036 SHALL abandon any RMW_WR in progress on reset assertion, issuing no write, and SHALL drop any pending rvalid.
REQ-037 SHALL accept requests in the first clock edge after rstn deasserts.

Verification
REQ-038 SHALL pass: i_req=1, i_addr=0x10 alone -> i_gnt=1 at T, mem_addr=4 at T, i_rvalid=1 at T+1 with i_rdata = mem_rdata.
REQ-039 SHALL pass: i_req and d_req held high for 8 cycles (loads), STARVE_MAX=3 -> grant pattern D,D,D,I,D,D,D,I.
REQ-040 SHALL pass: word 0x11223344 at 0x20, store d_be=4'b0010, d_wdata=0x0000AA00 -> read at T, write 0x1122AA44 at T+1, no grant at T+1.
REQ-041 SHALL pass: rstn pulsed low during RMW_WR -> no mem_we pulse, all outputs 0, word unchanged.
REQ-042 SHALL pass: full-word store of 0xDEADBEEF at 0x8, then load at 0x8 -> d_rvalid one cycle after the load grant with d_rdata = 0xDEADBEEF.
